sha1_wb_host: RTL
=================

SHA1_WB_HOST -- requirements
Module: sha1_wb_host

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h30000024, base of the SHA1 responder register window.
REQ-002 Parameter ACK_TIMEOUT, default 16, maximum cycles to wait for wbm_ack_i per transaction.
REQ-003 Parameter POLL_MAX, default 255, maximum OPS status reads before the job fails.
REQ-004 Port wb_clk_i, input, 1: clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Ports start (in, 1) and block_in (in, 512): job request and the message block to hash.
REQ-007 Ports busy (out, 1), digest_valid (out, 1), digest_out (out, 160) and error (out, 1): job status and result.
REQ-008 Ports wbm_cyc_o, wbm_stb_o, wbm_we_o (out, 1 each), wbm_sel_o (out, 4), wbm_adr_o (out, 32), wbm_dat_o (out, 32): Wishbone initiator outputs.
REQ-009 Ports wbm_ack_i (in, 1) and wbm_dat_i (in, 32): Wishbone responder inputs.

Function
REQ-010 The block SHALL accept start only in IDLE; it SHALL register block_in on that cycle and raise busy on the next cycle; start while busy SHALL be ignored.
REQ-011 The FSM SHALL step IDLE -> CHK_ID -> RST -> LOAD(x16) -> POLL -> READ(x5) -> STOP -> IDLE, with ERR reachable from any bus state.
REQ-012 CHK_ID SHALL read BASE+4; any value other than 32'h53484131 SHALL go to ERR.
REQ-013 RST SHALL write 32'h2 to BASE+8, which clears the on bit and pulses the engine reset.
REQ-014 LOAD SHALL write 16 words to BASE+C in order i=0..15, each word being block_in[32i+31:32i].
REQ-015 POLL SHALL read BASE+8 repeatedly; it SHALL advance when bit3 (DONE) is 1, and SHALL go to ERR when bit2 (PANIC) is 1 or after POLL_MAX reads.
REQ-016 READ SHALL issue 5 reads of BASE+10; read k SHALL land in digest_out[32k+31:32k]; a value of 32'hfffffff0 (EBUSY) SHALL go to ERR.
REQ-017 STOP SHALL write 32'h0 to BASE+8, then pulse digest_valid for exactly 1 cycle and drop busy.
REQ-018 digest_out SHALL hold its value until the next job's first digest read.
REQ-019 Each transaction SHALL hold cyc=stb=1 and sel=4'hF, with adr, we and dat stable, until ack is sampled high.
REQ-020 cyc and stb SHALL deassert on the edge where ack is sampled; read data SHALL be captured from wbm_dat_i on that same edge.
REQ-021 Between transactions there SHALL be at least 2 idle cycles, and ack sampled while stb is low SHALL be ignored (the responder can hold ack an extra cycle).
REQ-022 A write SHALL return 32'h1 (ACK) for MSG_IN writes; any other returned value SHALL go to ERR.
REQ-023 If ack does not arrive within ACK_TIMEOUT cycles of stb rising, the block SHALL drop cyc/stb and go to ERR.
REQ-024 ERR SHALL pulse error for 1 cycle, leave digest_valid low and return to IDLE; no further bus cycle SHALL occur.
REQ-025 A good job SHALL issue exactly 24+N transactions, where N is the number of status polls.

Reset
REQ-026 While reset is high, all outputs SHALL be 0 on the next edge, including cyc and stb, and the FSM, counters and captured block SHALL clear.
REQ-027 Reset asserted mid-job SHALL abort the job with no error pulse; the first job after reset SHALL begin from CHK_ID.

Structure
REQ-028 Package sha1_wb_pkg SHALL hold:
- register offsets (0x0, 0x4, 0x8, 0xC, 0x10);
- the ID, ACK, EINVAL and EBUSY constants;
- the OPS bit positions (ON=0, RESET=1, PANIC=2, DONE=3);
- the FSM state enum.
REQ-029 A single sub-module sha1_wb_xfer SHALL run one bus transaction. It SHALL:
- take req, we, adr and wdat as inputs;
- return done, rdata and timeout;
- own the strobe, the timeout counter and the idle gap.

Verification
REQ-030 Behavioural responder returning DONE on the 3rd poll and digest words 32'h11111111..32'h55555555 -> digest_out = 160'h5555555544444444333333332222222211111111, digest_valid pulses once, 27 transactions seen.
REQ-031 Full sha1_wb responder with the "abc" padded block -> digest_valid pulses; the 5 digest words are a permutation of a9993e36, 4706816a, ba3e2571, 7850c26c, 9cd0d89d in the core's word order; error stays 0.
REQ-032 ID read returns 32'hf00df00d -> error pulses 1 cycle; no write is ever issued.
REQ-033 Responder that never acks the 5th MSG_IN write -> cyc drops 16 cycles after stb rose, then error pulses.
REQ-034 Reset raised during POLL -> next edge all outputs 0; a following start runs a full good job.
REQ-035 Ack held 2 cycles on every transfer -> no duplicated or skipped word, and exactly 16 MSG_IN writes.

Source files
------------

// File: rtl/sha1_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wb_pkg
// Purpose  : Shared definitions for the SHA1 Wishbone host: responder
//            register offsets, status/return codes, OPS bit positions and
//            the host FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sha1_wb_pkg;

   // Responder register offsets relative to BASE_ADDRESS
   localparam logic [31:0] c_off_ctrl   = 32'h0000_0000;
   localparam logic [31:0] c_off_id     = 32'h0000_0004;
   localparam logic [31:0] c_off_ops    = 32'h0000_0008;
   localparam logic [31:0] c_off_msg    = 32'h0000_000C;
   localparam logic [31:0] c_off_digest = 32'h0000_0010;

   // Identification and return codes
   localparam logic [31:0] c_id_value   = 32'h5348_4131;  // "SHA1"
   localparam logic [31:0] c_ack        = 32'h0000_0001;
   localparam logic [31:0] c_einval     = 32'hFFFF_FFEA;  // -22
   localparam logic [31:0] c_ebusy      = 32'hFFFF_FFF0;  // -16

   // OPS register bit positions
   localparam int c_ops_on    = 0;
   localparam int c_ops_reset = 1;
   localparam int c_ops_panic = 2;
   localparam int c_ops_done  = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHK_ID = 3'd1,
      ST_RST    = 3'd2,
      ST_LOAD   = 3'd3,
      ST_POLL   = 3'd4,
      ST_READ   = 3'd5,
      ST_STOP   = 3'd6,
      ST_ERR    = 3'd7
   } sha1_state_t;

endpackage
`default_nettype wire

// File: rtl/sha1_wb_host_if.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wb_host_if
// Purpose  : Wishbone initiator bundle between the SHA1 host and the
//            SHA1 responder.
// Ports    : master modport drives cyc/stb/we/sel/adr/dat_o and samples
//            ack/dat_i; slave modport is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface sha1_wb_host_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface
`default_nettype wire

// File: rtl/sha1_wb_xfer.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wb_xfer
// Purpose  : Runs one Wishbone transaction at a time. Owns the strobe, the
//            ack timeout counter and the mandatory idle gap between cycles.
// Ports    : wb_clk_i, reset      - clock, synchronous active-high reset
//            req/we/adr/wdat      - request level and transfer attributes
//            done/rdata/timeout   - 1-cycle completion pulses, captured data
//            wbm                  - Wishbone initiator bundle
// Revision : 1.0 - initial release
// ============================================================================
module sha1_wb_xfer
   import sha1_wb_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  wire logic        wb_clk_i,
   input  wire logic        reset,
   input  wire logic        req,
   input  wire logic        we,
   input  wire logic [31:0] adr,
   input  wire logic [31:0] wdat,
   output logic             done,
   output logic [31:0]      rdata,
   output logic             timeout,
   sha1_wb_host_if.master   wbm
);

   localparam int c_to_w = $clog2(ACK_TIMEOUT + 1);
   localparam logic [c_to_w-1:0] c_to_last = c_to_w'(ACK_TIMEOUT - 1);
   // The gap counter is loaded on the ack edge; the idle cycles seen on the
   // bus are c_gap_load + 1, giving the required two.
   localparam logic [1:0] c_gap_load = 2'd1;

   logic              r_cyc;
   logic              r_stb;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [31:0]       r_adr;
   logic [31:0]       r_dat;
   logic [31:0]       r_rdata;
   logic              r_done;
   logic              r_timeout;
   logic [c_to_w-1:0] r_tcnt;
   logic [1:0]        r_gap;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= 4'h0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_rdata   <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_tcnt    <= '0;
         r_gap     <= '0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         if (r_stb) begin
            // ack only counts while our strobe is up; a stale ack held over
            // from the previous cycle lands in the gap and is ignored.
            if (wbm.wbm_ack_i) begin
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_sel   <= 4'h0;
               r_rdata <= wbm.wbm_dat_i;
               r_done  <= 1'b1;
               r_gap   <= c_gap_load;
            end else if (r_tcnt == c_to_last) begin
               r_cyc     <= 1'b0;
               r_stb     <= 1'b0;
               r_sel     <= 4'h0;
               r_timeout <= 1'b1;
               r_gap     <= c_gap_load;
            end else begin
               r_tcnt <= r_tcnt + 1'b1;
            end
         end else if (r_gap != 2'd0) begin
            r_gap <= r_gap - 1'b1;
         end else if (req) begin
            r_cyc  <= 1'b1;
            r_stb  <= 1'b1;
            r_sel  <= 4'hF;
            r_we   <= we;
            r_adr  <= adr;
            r_dat  <= wdat;
            r_tcnt <= '0;
         end
      end
   end

   assign wbm.wbm_cyc_o = r_cyc;
   assign wbm.wbm_stb_o = r_stb;
   assign wbm.wbm_we_o  = r_we;
   assign wbm.wbm_sel_o = r_sel;
   assign wbm.wbm_adr_o = r_adr;
   assign wbm.wbm_dat_o = r_dat;
   assign done          = r_done;
   assign rdata         = r_rdata;
   assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: rtl/sha1_wb_host.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wb_host
// Purpose  : Drives a SHA1 responder over Wishbone: checks its ID, resets
//            the engine, loads a 512-bit block, polls for completion, reads
//            back the 160-bit digest and stops the engine.
// Ports    : wb_clk_i, reset           - clock, synchronous active-high reset
//            start, block_in           - job request and message block
//            busy, digest_valid,
//            digest_out, error         - job status and result
//            wbm                       - Wishbone initiator bundle
// Revision : 1.0 - initial release
// ============================================================================
module sha1_wb_host
   import sha1_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
   parameter int          ACK_TIMEOUT  = 16,
   parameter int          POLL_MAX     = 255
) (
   input  wire logic         wb_clk_i,
   input  wire logic         reset,
   input  wire logic         start,
   input  wire logic [511:0] block_in,
   output logic              busy,
   output logic              digest_valid,
   output logic [159:0]      digest_out,
   output logic              error,
   sha1_wb_host_if.master    wbm
);

   localparam int c_poll_w = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
   localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_MAX - 1);
   localparam logic [31:0] c_ops_rst_word = 32'h1 << c_ops_reset;

   sha1_state_t         r_state;
   logic                r_busy;
   logic                r_digest_valid;
   logic                r_error;
   logic [159:0]        r_digest;
   logic [511:0]        r_block;
   logic                r_req;
   logic                r_we;
   logic [31:0]         r_adr;
   logic [31:0]         r_wdat;
   logic [3:0]          r_idx;
   logic [c_poll_w-1:0] r_polls;

   logic                w_done;
   logic                w_timeout;
   logic [31:0]         w_rdata;

   sha1_wb_xfer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .wb_clk_i (wb_clk_i),
      .reset    (reset),
      .req      (r_req),
      .we       (r_we),
      .adr      (r_adr),
      .wdat     (r_wdat),
      .done     (w_done),
      .rdata    (w_rdata),
      .timeout  (w_timeout),
      .wbm      (wbm)
   );

   // r_req stays high for the whole bus phase; the transfer engine's idle gap
   // keeps the next request from launching until attributes have been updated
   // on the cycle after done. Dropping r_req on the way to ERR therefore
   // guarantees no further bus cycle.
   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_busy         <= 1'b0;
         r_digest_valid <= 1'b0;
         r_error        <= 1'b0;
         r_digest       <= '0;
         r_block        <= '0;
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_adr          <= '0;
         r_wdat         <= '0;
         r_idx          <= '0;
         r_polls        <= '0;
      end else begin
         r_digest_valid <= 1'b0;
         r_error        <= 1'b0;
         if (w_timeout) begin
            r_req   <= 1'b0;
            r_state <= ST_ERR;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_block <= block_in;
                     r_busy  <= 1'b1;
                     r_req   <= 1'b1;
                     r_we    <= 1'b0;
                     r_adr   <= BASE_ADDRESS + c_off_id;
                     r_wdat  <= '0;
                     r_state <= ST_CHK_ID;
                  end
               end
               ST_CHK_ID: begin
                  if (w_done) begin
                     if (w_rdata != c_id_value) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                     end else begin
                        r_we    <= 1'b1;
                        r_adr   <= BASE_ADDRESS + c_off_ops;
                        r_wdat  <= c_ops_rst_word;
                        r_state <= ST_RST;
                     end
                  end
               end
               ST_RST: begin
                  if (w_done) begin
                     r_adr   <= BASE_ADDRESS + c_off_msg;
                     r_wdat  <= r_block[31:0];
                     r_idx   <= '0;
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (w_done) begin
                     if (w_rdata != c_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                     end else if (r_idx == 4'd15) begin
                        r_we    <= 1'b0;
                        r_adr   <= BASE_ADDRESS + c_off_ops;
                        r_wdat  <= '0;
                        r_polls <= '0;
                        r_state <= ST_POLL;
                     end else begin
                        r_idx  <= r_idx + 4'd1;
                        r_wdat <= r_block[{r_idx + 4'd1, 5'd0} +: 32];
                     end
                  end
               end
               ST_POLL: begin
                  if (w_done) begin
                     if (w_rdata[c_ops_panic]) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                     end else if (w_rdata[c_ops_done]) begin
                        r_adr   <= BASE_ADDRESS + c_off_digest;
                        r_idx   <= '0;
                        r_state <= ST_READ;
                     end else if (r_polls == c_poll_last) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                     end else begin
                        r_polls <= r_polls + 1'b1;
                     end
                  end
               end
               ST_READ: begin
                  if (w_done) begin
                     if (w_rdata == c_ebusy) begin
                        r_req   <= 1'b0;
                        r_state <= ST_ERR;
                     end else begin
                        r_digest[{r_idx[2:0], 5'd0} +: 32] <= w_rdata;
                        if (r_idx == 4'd4) begin
                           r_we    <= 1'b1;
                           r_adr   <= BASE_ADDRESS + c_off_ops;
                           r_wdat  <= '0;
                           r_state <= ST_STOP;
                        end else begin
                           r_idx <= r_idx + 4'd1;
                        end
                     end
                  end
               end
               ST_STOP: begin
                  if (w_done) begin
                     r_req          <= 1'b0;
                     r_busy         <= 1'b0;
                     r_digest_valid <= 1'b1;
                     r_state        <= ST_IDLE;
                  end
               end
               ST_ERR: begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy         = r_busy;
   assign digest_valid = r_digest_valid;
   assign digest_out   = r_digest;
   assign error        = r_error;

endmodule
`default_nettype wire
